// File: rtl/id_ex_pipe.sv
// ID/EX elastic pipeline register: a main entry drives the outputs, a skid entry
// absorbs one overflow. Optional counters under ID_EX_PIPE_PERF_EN.
module id_ex_pipe #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int WB_W = 2,
    parameter int M_W  = 3,
    parameter int EX_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WB_W+M_W+EX_W-1:0]   in_ctl,
    input  logic [4*XLEN-1:0]          in_data,
    input  logic [3*REGW-1:0]          in_regs,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WB_W-1:0]            out_wb,
    output logic [M_W-1:0]             out_m,
    output logic                       out_regdst,
    output logic [EX_W-3:0]            out_aluop,
    output logic                       out_alusrc,
    output logic [4*XLEN-1:0]          out_data,
    output logic [3*REGW-1:0]          out_regs
`ifdef ID_EX_PIPE_PERF_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
`endif
);

    localparam int CTL_W = WB_W + M_W + EX_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CTL_W-1:0]  main_ctl,  skid_ctl;
    logic [4*XLEN-1:0] main_data, skid_data;
    logic [3*REGW-1:0] main_regs, skid_regs;

    logic accept, drain;
    logic load_main_in, load_main_skid, load_skid;

    // flush blocks acceptance so a squashed cycle never captures its input
    assign accept = in_valid && in_ready && !flush;
    assign drain  = out_valid && out_ready;

    // next-state and register-load selection
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_nxt    = FULL;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = SKID;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (drain) begin
                        load_main_skid = 1'b1;
                        state_nxt      = FULL;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // state plus registered handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != SKID);
            out_valid <= (state_nxt != EMPTY);
        end
    end

    // main entry: loaded from the input or promoted from the skid entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_ctl  <= '0;
            main_data <= '0;
            main_regs <= '0;
        end else if (load_main_in) begin
            main_ctl  <= in_ctl;
            main_data <= in_data;
            main_regs <= in_regs;
        end else if (load_main_skid) begin
            main_ctl  <= skid_ctl;
            main_data <= skid_data;
            main_regs <= skid_regs;
        end
    end

    // skid entry: catches the input accepted while the output is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_ctl  <= '0;
            skid_data <= '0;
            skid_regs <= '0;
        end else if (load_skid) begin
            skid_ctl  <= in_ctl;
            skid_data <= in_data;
            skid_regs <= in_regs;
        end
    end

    // wb/m are gated to a bubble when no entry is valid
    assign out_wb     = out_valid ? main_ctl[CTL_W-1 -: WB_W] : '0;
    assign out_m      = out_valid ? main_ctl[EX_W +: M_W] : '0;
    assign out_regdst = main_ctl[EX_W-1];
    assign out_aluop  = main_ctl[EX_W-2:1];
    assign out_alusrc = main_ctl[0];
    assign out_data   = main_data;
    assign out_regs   = main_regs;

`ifdef ID_EX_PIPE_PERF_EN
    // saturating stall and flush event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && state != EMPTY && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    // counters are not built in this configuration
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe.
// Counter checks are compiled in with ID_EX_PIPE_PERF_EN.
module tb_id_ex_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [8:0]   in_ctl;
    logic [127:0] in_data;
    logic [14:0]  in_regs;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_wb;
    logic [2:0]   out_m;
    logic         out_regdst;
    logic [1:0]   out_aluop;
    logic         out_alusrc;
    logic [127:0] out_data;
    logic [14:0]  out_regs;
`ifdef ID_EX_PIPE_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctl     (in_ctl),
        .in_data    (in_data),
        .in_regs    (in_regs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_wb     (out_wb),
        .out_m      (out_m),
        .out_regdst (out_regdst),
        .out_aluop  (out_aluop),
        .out_alusrc (out_alusrc),
        .out_data   (out_data),
        .out_regs   (out_regs)
`ifdef ID_EX_PIPE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_data  = {pc, pc + 32'h1, pc + 32'h2, pc + 32'h3};
    endtask

    function automatic logic [31:0] pc_of(input logic [127:0] d);
        return d[127:96];
    endfunction

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctl    = '0;
        in_data   = '0;
        in_regs   = '0;
        out_ready = 1'b0;

        // reset state
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_wb", out_wb, 0);
        #9 reset = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // single entry, 1-cycle latency, field slicing
        in_ctl    = {2'b11, 3'b010, 4'b1011};
        in_regs   = {5'd1, 5'd2, 5'd3};
        in_valid  = 1'b1;
        in_data   = {32'h100, 32'h11, 32'h22, 32'hFFFF_FFF0};
        out_ready = 1'b1;
        step();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data,
              {32'h100, 32'h11, 32'h22, 32'hFFFF_FFF0});
        check("t1_in_ready", in_ready, 1);
        check("t1_regdst", out_regdst, 1);
        check("t1_aluop", out_aluop, 2'b01);
        check("t1_alusrc", out_alusrc, 1);
        check("t1_wb", out_wb, 3);
        check("t1_m", out_m, 2);
        check("t1_regs", out_regs, {5'd1, 5'd2, 5'd3});
        in_valid = 1'b0;
        step();
        check("t1_drained", out_valid, 0);
        check("t1_bubble_wb", out_wb, 0);
        check("t1_bubble_m", out_m, 0);
        check("t1_in_ready2", in_ready, 1);

        // backpressure into skid, then ordered drain
        out_ready = 1'b0;
        send(1'b1, 32'h0);
        step();
        check("t2_pc0", pc_of(out_data), 32'h0);
        check("t2_ready_full", in_ready, 1);
        send(1'b1, 32'h4);
        step();
        check("t2_skid_ready", in_ready, 0);
        check("t2_hold0", pc_of(out_data), 32'h0);
        send(1'b1, 32'h8);
        step();
        check("t2_still_skid", in_ready, 0);
        check("t2_hold0b", pc_of(out_data), 32'h0);
        check("t2_hold_wb", out_wb, 3);
        out_ready = 1'b1;
        step();
        check("t2_pc4", pc_of(out_data), 32'h4);
        check("t2_ready_back", in_ready, 1);
        step();
        check("t2_pc8", pc_of(out_data), 32'h8);
        check("t2_valid8", out_valid, 1);
        send(1'b0, 32'h0);
        step();
        check("t2_empty", out_valid, 0);
`ifdef ID_EX_PIPE_PERF_EN
        check("t2_stall_cnt", stall_cnt, 2);
`endif

        // flush from SKID with a same-cycle input
        out_ready = 1'b0;
        send(1'b1, 32'h10);
        step();
        send(1'b1, 32'h14);
        step();
        check("t3_in_skid", in_ready, 0);
        send(1'b1, 32'h18);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_flush_valid", out_valid, 0);
        check("t3_flush_ready", in_ready, 1);
        check("t3_flush_wb", out_wb, 0);
        check("t3_flush_m", out_m, 0);
`ifdef ID_EX_PIPE_PERF_EN
        check("t3_flush_cnt", flush_cnt, 1);
        check("t3_stall_cnt", stall_cnt, 4);
`endif
        send(1'b0, 32'h0);
        out_ready = 1'b1;
        step();
        check("t3_no_ghost", out_valid, 0);

        // back-to-back throughput
        send(1'b1, 32'h20);
        step();
        check("t4_pc20", pc_of(out_data), 32'h20);
        send(1'b1, 32'h24);
        step();
        check("t4_pc24", pc_of(out_data), 32'h24);
        check("t4_ready24", in_ready, 1);
        send(1'b1, 32'h28);
        step();
        check("t4_pc28", pc_of(out_data), 32'h28);
        check("t4_valid28", out_valid, 1);
        send(1'b0, 32'h0);
        step();
        check("t4_empty", out_valid, 0);
        // flushing an empty stage is not a discard
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_empty_flush_valid", out_valid, 0);
`ifdef ID_EX_PIPE_PERF_EN
        check("t4_flush_cnt_same", flush_cnt, 1);
`endif

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(1'b1, 32'h30);
        step();
        check("t5_loaded", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 0);
        check("t5_async_ready", in_ready, 0);
        check("t5_async_regs", out_regs, 0);
        check("t5_async_wb", out_wb, 0);
`ifdef ID_EX_PIPE_PERF_EN
        check("t5_async_stall", stall_cnt, 0);
        check("t5_async_flush", flush_cnt, 0);
`endif
        send(1'b0, 32'h0);
        #10 reset = 1'b0;
        step();
        check("t5_ready_after", in_ready, 1);
        check("t5_valid_after", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
